// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/ack bundle for the two requesters plus the RAM-side port.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  req0, req1, we0, we1, ack0, ack1, busy, ram_we;
    logic [ADDR_WIDTH-1:0] addr0, addr1, ram_addr;
    logic [DATA_WIDTH-1:0] wdata0, wdata1, rdata0, rdata1, ram_wdata, ram_q;
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        output ack0, ack1, rdata0, rdata1, busy, ram_addr, ram_wdata, ram_we
    );
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        input  ack0, ack1, rdata0, rdata1, busy, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter sequencing one RAM access per grant
// (IDLE -> ACCESS -> RESP) with registered RAM drive and registered read data.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                state, state_nxt;
    logic                  grant, last_grant, winner, start, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, rdata0, rdata1;
    always_comb begin
        start     = 1'b0;
        state_nxt = IDLE;
        winner    = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
        case (state)
            IDLE: begin
                start     = bus.req0 | bus.req1;
                state_nxt = start ? ACCESS : IDLE;
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ram_we <= start & (winner ? bus.we1 : bus.we0);
            if (start) begin
                grant      <= winner;
                last_grant <= winner;
                ram_addr   <= winner ? bus.addr1 : bus.addr0;
                ram_wdata  <= winner ? bus.wdata1 : bus.wdata0;
            end
            // ram_q is sampled on the edge closing ACCESS; only reads update rdata
            if (state == ACCESS && !ram_we) begin
                if (grant) rdata1 <= bus.ram_q;
                else       rdata0 <= bus.ram_q;
            end
        end
    end
    assign bus.ack0      = (state == RESP) & ~grant;
    assign bus.ack1      = (state == RESP) & grant;
    assign bus.busy      = (state != IDLE);
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.rdata0    = rdata0;
    assign bus.rdata1    = rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected acks are queued at request time and
// checked in grant order, with a behavioral RAM attached to the arbiter.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam logic [DW-1:0] D01 = 32'h1111_1111;
    localparam logic [DW-1:0] D02 = 32'h2222_2222;

    typedef struct {
        bit            port;
        bit            we;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DW-1:0] mem [256];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end
    assign bus.ram_q = mem[bus.ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   hold0 = 1'b0;
    bit   cont0 = 1'b0;
    bit   cont1 = 1'b0;
    int   ack_cyc[8];
    bit   ack_port[8];
    int   n_ack = 0;

    task automatic monitor();
        exp_t          e;
        logic [DW-1:0] rd;
        forever begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                if (n_ack < 8) begin
                    ack_cyc[n_ack]  = cyc;
                    ack_port[n_ack] = bus.ack1;
                end
                n_ack++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ack: ack0=%b ack1=%b at cycle %0d, required no ack", bus.ack0, bus.ack1, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.ack1 !== e.port || bus.ack0 === bus.ack1) begin
                        n_bad++;
                        $display("FAIL ack_port: ack0=%b ack1=%b, required port %0d only", bus.ack0, bus.ack1, e.port);
                    end
                    if (!e.we) begin
                        n_cmp++;
                        rd = e.port ? bus.rdata1 : bus.rdata0;
                        if (rd !== e.data) begin
                            n_bad++;
                            $display("FAIL rdata%0d: got %h, required %h", e.port, rd, e.data);
                        end
                    end
                    if (e.cyc != 0) begin
                        n_cmp++;
                        if (cyc != e.cyc) begin
                            n_bad++;
                            $display("FAIL ack_cycle: port %0d ack at %0d, required %0d", e.port, cyc, e.cyc);
                        end
                    end
                end
                if (bus.ack0 && !hold0) bus.req0 = 1'b0;
                if (bus.ack1) bus.req1 = 1'b0;
            end else begin
                if (cont0 && !bus.req0) begin
                    bus.req0 = 1'b1;
                    sb.push_back('{port: 1'b0, we: 1'b0, data: D01, cyc: 0});
                end
                if (cont1 && !bus.req1) begin
                    bus.req1 = 1'b1;
                    sb.push_back('{port: 1'b1, we: 1'b0, data: D02, cyc: 0});
                end
            end
        end
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        ok = (sb.size() == 0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        preload(8'h10, 32'hDEAD_BEEF);
        preload(8'h01, D01);
        preload(8'h02, D02);
        preload(8'h20, 32'h0);
        preload(8'hFF, 32'h0);
        #1;
        n_cmp++;
        if ({bus.ack0, bus.ack1, bus.busy, bus.ram_we} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: ack0/ack1/busy/ram_we=%b, required 0000", {bus.ack0, bus.ack1, bus.busy, bus.ram_we});
        end
        n_cmp++;
        if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_ram: ram_addr=%h ram_wdata=%h, required 0", bus.ram_addr, bus.ram_wdata);
        end
        n_cmp++;
        if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata: rdata0=%h rdata1=%h, required 0", bus.rdata0, bus.rdata1);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_tie();
        int c;
        bit ok;
        @(negedge clk);
        c = cyc;
        bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.we1 = 1'b0; bus.addr1 = 8'h02;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        sb.push_back('{port: 1'b0, we: 1'b0, data: D01, cyc: c + 2});
        sb.push_back('{port: 1'b1, we: 1'b0, data: D02, cyc: c + 5});
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL tie_timeout: %0d acks outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_single_read();
        int c;
        bit ok;
        @(negedge clk);
        c = cyc;
        bus.we0 = 1'b0; bus.addr0 = 8'h10; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, we: 1'b0, data: 32'hDEAD_BEEF, cyc: c + 2});
        @(negedge clk);
        n_cmp++;
        if (bus.ram_addr !== 8'h10 || bus.ram_we !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL read_access: ram_addr=%h ram_we=%b busy=%b, required 10 0 1", bus.ram_addr, bus.ram_we, bus.busy);
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL read_timeout: %0d acks outstanding, required 0", sb.size()); sb.delete(); end
        n_cmp++;
        if (bus.rdata1 !== D02) begin
            n_bad++;
            $display("FAIL rdata1_hold: got %h, required %h", bus.rdata1, D02);
        end
    endtask

    task automatic test_write_read();
        int c;
        int nwe = 0;
        bit ok;
        @(negedge clk);
        c = cyc;
        bus.we1 = 1'b1; bus.addr1 = 8'hFF; bus.wdata1 = 32'h1234_5678; bus.req1 = 1'b1;
        sb.push_back('{port: 1'b1, we: 1'b1, data: '0, cyc: c + 2});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) begin
                nwe++;
                n_cmp++;
                if (bus.ram_addr !== 8'hFF || bus.ram_wdata !== 32'h1234_5678) begin
                    n_bad++;
                    $display("FAIL write_bus: ram_addr=%h ram_wdata=%h, required ff 12345678", bus.ram_addr, bus.ram_wdata);
                end
            end
        end
        n_cmp++;
        if (nwe != 1) begin n_bad++; $display("FAIL write_we_cycles: ram_we high %0d cycles, required 1", nwe); end
        drain(ok);
        @(negedge clk);
        c = cyc;
        bus.we0 = 1'b0; bus.addr0 = 8'hFF; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, we: 1'b0, data: 32'h1234_5678, cyc: c + 2});
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wr_rd_timeout: %0d acks outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_held_req();
        int c;
        bit ok;
        bit busy_exp [1:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        c = cyc;
        hold0 = 1'b1;
        bus.we0 = 1'b0; bus.addr0 = 8'h10; bus.req0 = 1'b1;
        sb.push_back('{port: 1'b0, we: 1'b0, data: 32'hDEAD_BEEF, cyc: c + 2});
        sb.push_back('{port: 1'b0, we: 1'b0, data: 32'hDEAD_BEEF, cyc: c + 5});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 3) hold0 = 1'b0;
            n_cmp++;
            if (bus.busy !== busy_exp[i]) begin
                n_bad++;
                $display("FAIL held_busy: cycle +%0d busy=%b, required %b", i, bus.busy, busy_exp[i]);
            end
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL held_timeout: %0d acks outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_contention();
        bit ok;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_ack = 0;
        bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.we1 = 1'b0; bus.addr1 = 8'h02;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        sb.push_back('{port: 1'b0, we: 1'b0, data: D01, cyc: 0});
        sb.push_back('{port: 1'b1, we: 1'b0, data: D02, cyc: 0});
        cont0 = 1'b1; cont1 = 1'b1;
        for (int i = 0; i < 30 && n_ack < 4; i++) @(negedge clk);
        cont0 = 1'b0; cont1 = 1'b0;
        drain(ok);
        n_cmp++;
        if (!ok || n_ack < 4) begin
            n_bad++;
            $display("FAIL cont_timeout: %0d acks seen, %0d outstanding, required >=4 and 0", n_ack, sb.size());
            sb.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ack_port[i] !== i[0]) begin
                    n_bad++;
                    $display("FAIL cont_order: ack %0d from port %0d, required %0d", i, ack_port[i], i[0]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ack_cyc[i+1] - ack_cyc[i] != 3) begin
                    n_bad++;
                    $display("FAIL cont_spacing: gap %0d, required 3", ack_cyc[i+1] - ack_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 32'hAAAA_AAAA; bus.req0 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL mid_we_access: ram_we=%b, required 1", bus.ram_we); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ack0, bus.ack1, bus.busy, bus.ram_we} !== 4'b0) begin
            n_bad++;
            $display("FAIL mid_reset_ctrl: ack0/ack1/busy/ram_we=%b, required 0000", {bus.ack0, bus.ack1, bus.busy, bus.ram_we});
        end
        n_cmp++;
        if (bus.ram_addr !== '0 || bus.ram_wdata !== '0 || bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_data: ram_addr=%h ram_wdata=%h rdata0=%h rdata1=%h, required 0", bus.ram_addr, bus.ram_wdata, bus.rdata0, bus.rdata1);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (mem[8'h20] !== 32'h0) begin n_bad++; $display("FAIL mid_no_commit: RAM[20]=%h, required 0", mem[8'h20]); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle: busy=%b, required 0", bus.busy); end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_tie();
        test_single_read();
        test_write_read();
        test_held_req();
        test_contention();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the single-port data memory RAM (synchronous write, asynchronous read). It sits between two requesters, the pipeline MEM stage on port 0 and the program/debug loader on port 1, and the RAM instance. It grants one access at a time using round-robin priority, drives the RAM address, data and write-enable from registers, and returns a one-cycle acknowledge with registered read data.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width; must match the RAM.
- ADDR_WIDTH, 8, word address width; must match the RAM.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request, level-sensitive, held until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; valid while reqN is high.
- addr0, addr1  in  ADDR_WIDTH  word address; valid while reqN is high.
- wdata0, wdata1  in  DATA_WIDTH  write data; valid while reqN is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  DATA_WIDTH  read result, registered; valid when ackN is high after a read.
- busy  out  1  high while state is not IDLE.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_q  in  DATA_WIDTH  RAM asynchronous read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. There are no other states; illegal encodings return to IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner, latch grant (1 bit), load ram_addr, ram_wdata and ram_we (= weN of the winner) from the winner's inputs, and go to ACCESS.
- Arbitration:
  - If only one reqN is high, that port wins.
  - If both are high, the port that is not last_grant wins.
  - last_grant updates to the winner on the IDLE→ACCESS transition.
  - last_grant resets to 1, so port 0 wins the first tie.
- ACCESS, exactly one cycle:
  - The RAM sees a stable address, and for writes ram_we = 1; the write commits on the closing edge.
  - For reads, ram_q is captured on the closing edge into rdataN of the granted port only. The other port's rdata holds its value.
  - On the closing edge ram_we clears to 0 and the FSM goes to RESP.
- RESP, exactly one cycle:
  - ackN of the granted port is 1; the other ack is 0.
  - After a write, rdataN is unchanged.
  - The FSM then returns to IDLE.
- Request inputs are ignored in ACCESS and RESP.
- A requester samples ack and must drop req on the following edge. If req is still high in IDLE, it counts as a new request.
- ram_addr and ram_wdata hold their last values outside ACCESS. ram_we is 1 only in ACCESS and only for writes.
- busy = (state != IDLE).

## Timing
- Reset values, applied asynchronously while reset = 0:
  - state = IDLE, last_grant = 1, grant = 0.
  - ack0 = ack1 = 0, ram_we = 0, busy = 0.
  - ram_addr = 0, ram_wdata = 0, rdata0 = rdata1 = 0.
- Latency: request sampled at edge k, ACCESS in cycle k+1, ack high in cycle k+2. The ack-to-next-grant gap is 1 cycle (IDLE).
- Throughput: at most one access per 3 cycles. With both ports continuously requesting, grants alternate 0,1,0,1…
- A simultaneous request of both ports on the same edge is resolved by round-robin; no request is ever lost or duplicated.
- Reset asserted during ACCESS:
  - ram_we drops immediately, so a write is not committed unless the closing edge already occurred.
  - No ack is issued, and the requester must re-request.
- Reset asserted during RESP: the ack is cut short immediately.
- Address wrap: there is no arithmetic on addresses. Address 2**ADDR_WIDTH-1 is accessed exactly like any other.
- A read of an address written by the immediately preceding grant returns the new data, because the write has committed before the next ACCESS.

## Test plan
- Single read: RAM[0x10] preloaded 0xDEADBEEF; pulse req0 with we0 = 0, addr0 = 0x10 → ram_addr = 0x10 in cycle k+1, ack0 = 1 with rdata0 = 0xDEADBEEF in cycle k+2, ack1 stays 0, rdata1 unchanged.
- Write then read: port 1 writes 0x12345678 to 0xFF → ram_we high exactly one cycle, ack1 after 2 cycles; a following port 0 read of 0xFF returns 0x12345678.
- Tie after reset: req0 and req1 rise on the same edge (reads of 0x01 and 0x02) → port 0 is served first (ack0 at k+2), port 1 is served next (ack1 at k+5).
- Continuous contention: both reqs held high for 12 cycles, each dropped for one cycle after its ack and then reasserted → strictly alternating acks 0,1,0,1 at a 3-cycle spacing.
- Reset mid-write: start a port 0 write of 0xAAAAAAAA to 0x20 (RAM[0x20] = 0); assert reset during ACCESS before the edge → ram_we = 0 immediately, no ack, RAM[0x20] still 0, all outputs at their reset values.
- Held req: req0 kept high through ack and the next cycle → a second access of the same address with a second ack0 at k+5; busy is low only in the IDLE cycles.
